// File: rtl/ucie_ctl_sb_pkg.sv
// Shared constants and state encoding for the UCIe sideband TX path.
package ucie_ctl_sb_pkg;

    localparam int PKT_W_C = 64;
    localparam int GAP_C   = 32;

    typedef enum logic [1:0] {
        SB_IDLE  = 2'd0,
        SB_SHIFT = 2'd1,
        SB_GAP   = 2'd2
    } sb_ser_states_e;

endpackage

// File: rtl/ucie_ctl_phy_sb_tx_serializer_if.sv
// Sideband message word stream into the serializer, with the credit return.
interface ucie_ctl_phy_sb_tx_serializer_if #(
    parameter int NC = 32
);

    logic          sb_data_valid;
    logic [NC-1:0] sb_data;
    logic          cfg_crd;

    modport master (
        output sb_data_valid,
        output sb_data,
        input  cfg_crd
    );

    modport slave (
        input  sb_data_valid,
        input  sb_data,
        output cfg_crd
    );

endinterface

// File: rtl/ucie_ctl_sb_pkt_fifo.sv
// Synchronous packet FIFO; pointers carry one extra wrap bit for full/empty.
module ucie_ctl_sb_pkt_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PONE = (AW+1)'(1);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         wr_en;
    logic         rd_en;

    assign o_empty = (wr_q == rd_q);
    assign o_full  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign o_level = wr_q - rd_q;
    assign o_data  = mem[rd_q[AW-1:0]];

    // A push while full is legal only when the head leaves on the same edge.
    assign wr_en = i_push && (!o_full || i_pop);
    assign rd_en = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + PONE;
            if (rd_en) rd_q <= rd_q + PONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/ucie_ctl_phy_sb_tx_serializer.sv
// Sideband TX serializer: word assembly, packet FIFO, bit shifter with idle gap.
// Optional packet counter enabled by UCIE_CTL_SB_TX_PKT_CNT_EN.
module ucie_ctl_phy_sb_tx_serializer
    import ucie_ctl_sb_pkg::*;
#(
    parameter int NC    = 32,
    parameter int PKT_W = PKT_W_C,
    parameter int DEPTH = 4,
    parameter int GAP   = GAP_C
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    ucie_ctl_phy_sb_tx_serializer_if.slave     sb,
    output logic                               o_sb_ser_data,
    output logic                               o_sb_clk_en,
    output logic                               o_sb_busy,
    output logic                               o_ovf,
    output logic [15:0]                        o_pkt_cnt
);

    localparam int NW = PKT_W / NC;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam int IW = $clog2(PKT_W);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int AW = $clog2(DEPTH);

    localparam logic [WW-1:0] WONE = WW'(1);
    localparam logic [IW-1:0] IONE = IW'(1);
    localparam logic [GW-1:0] GONE = GW'(1);

    sb_ser_states_e state_q, state_d;

    logic [WW-1:0]    wcnt_q;
    logic [PKT_W-1:0] asm_q, asm_d;
    logic             last_w;

    logic [PKT_W-1:0] sh_q, sh_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             ser_d, en_d, load, pop, push, ovf_set;
    logic             crd_q, busy_d;

    logic [PKT_W-1:0] fifo_data;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_lvl, lvl_n;

    assign last_w  = sb.sb_data_valid && (wcnt_q == WW'(NW-1));
    assign push    = last_w && (!fifo_full || pop);
    assign ovf_set = last_w && fifo_full && !pop;
    assign sb.cfg_crd = crd_q;

    always_comb begin
        asm_d = asm_q;
        asm_d[wcnt_q*NC +: NC] = sb.sb_data;
    end

    ucie_ctl_sb_pkt_fifo #(
        .W     (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  (asm_d),
        .o_data  (fifo_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty),
        .o_level (fifo_lvl)
    );

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        load    = 1'b0;
        ser_d   = 1'b0;
        en_d    = 1'b0;
        unique case (1'b1)
            (state_q == SB_IDLE): begin
                load = !fifo_empty;
            end
            (state_q == SB_SHIFT): begin
                if (idx_q == IW'(PKT_W-1)) begin
                    state_d = SB_GAP;
                    gcnt_d  = '0;
                end else begin
                    ser_d = sh_q[0];
                    en_d  = 1'b1;
                    sh_d  = sh_q >> 1;
                    idx_d = idx_q + IONE;
                end
            end
            (state_q == SB_GAP): begin
                if (gcnt_q == GW'(GAP-1)) begin
                    load    = !fifo_empty;
                    state_d = fifo_empty ? SB_IDLE : state_q;
                end else begin
                    gcnt_d = gcnt_q + GONE;
                end
            end
            default: state_d = SB_IDLE;
        endcase
        // Loading drives bit 0 immediately; the register keeps the rest.
        if (load) begin
            state_d = SB_SHIFT;
            ser_d   = fifo_data[0];
            en_d    = 1'b1;
            sh_d    = fifo_data >> 1;
            idx_d   = '0;
        end
        pop    = load;
        lvl_n  = fifo_lvl + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        busy_d = (state_d != SB_IDLE) || (lvl_n != '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wcnt_q <= '0;
            asm_q  <= '0;
        end else if (sb.sb_data_valid) begin
            asm_q  <= asm_d;
            wcnt_q <= last_w ? '0 : wcnt_q + WONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= SB_IDLE;
            sh_q          <= '0;
            idx_q         <= '0;
            gcnt_q        <= '0;
            o_sb_ser_data <= 1'b0;
            o_sb_clk_en   <= 1'b0;
            o_sb_busy     <= 1'b0;
            o_ovf         <= 1'b0;
            crd_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            sh_q          <= sh_d;
            idx_q         <= idx_d;
            gcnt_q        <= gcnt_d;
            o_sb_ser_data <= ser_d;
            o_sb_clk_en   <= en_d;
            o_sb_busy     <= busy_d;
            o_ovf         <= o_ovf | ovf_set;
            crd_q         <= pop;
        end
    end

`ifdef UCIE_CTL_SB_TX_PKT_CNT_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_cnt_q <= '0;
        end else if (pop) begin
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
    end

    assign o_pkt_cnt = pkt_cnt_q;
`else
    assign o_pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_ucie_ctl_phy_sb_tx_serializer.sv
// Bench for the sideband TX serializer: directed scenarios with random payloads.
module tb_ucie_ctl_phy_sb_tx_serializer;

    localparam int NC    = 32;
    localparam int DEPTH = 4;
    localparam int GAP   = 32;
    localparam int PW    = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ser, en, busy, ovf;
    logic [15:0] pcnt;

    ucie_ctl_phy_sb_tx_serializer_if #(.NC(NC)) sbif ();

    ucie_ctl_phy_sb_tx_serializer #(
        .NC    (NC),
        .PKT_W (PW),
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .sb            (sbif),
        .o_sb_ser_data (ser),
        .o_sb_clk_en   (en),
        .o_sb_busy     (busy),
        .o_ovf         (ovf),
        .o_pkt_cnt     (pcnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Line monitor: rebuilds packets from the serial lane and logs gap lengths.
    logic [63:0] rxq[$];
    int          gaps[$];
    logic [63:0] cur;
    int          bitcnt, low_run, crd_cnt, en_cyc, bad_idle, bad_burst;
    longint      ncyc = 0;
    longint      first_hi, last_hi;
    bit          prev_en, have_burst;

    always @(negedge clk) begin
        ncyc++;
        if (!rst_n) begin
            bitcnt = 0;
            low_run = 0;
            prev_en = 1'b0;
            have_burst = 1'b0;
        end else begin
            if (en) begin
                if (!prev_en && have_burst) gaps.push_back(low_run);
                cur[bitcnt] = ser;
                bitcnt++;
                en_cyc++;
                if (first_hi < 0) first_hi = ncyc;
                last_hi = ncyc;
                if (bitcnt == PW) begin
                    rxq.push_back(cur);
                    bitcnt = 0;
                    have_burst = 1'b1;
                end
                low_run = 0;
            end else begin
                if (bitcnt != 0) bad_burst++;
                if (ser) bad_idle++;
                low_run++;
            end
            if (sbif.cfg_crd) crd_cnt++;
            prev_en = en;
        end
    end

    logic [63:0] expq[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send_word(input logic [NC-1:0] w);
        sbif.sb_data_valid = 1'b1;
        sbif.sb_data = w;
        tick();
        sbif.sb_data_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] p);
        send_word(p[31:0]);
        send_word(p[63:32]);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [15:0] exp_cnt(input int n);
`ifdef UCIE_CTL_SB_TX_PKT_CNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    task automatic clear_mon();
        rxq.delete();
        gaps.delete();
        expq.delete();
        crd_cnt = 0;
        en_cyc = 0;
        bad_idle = 0;
        bad_burst = 0;
        first_hi = -1;
        last_hi = -1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_mon();
        idle(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        tick();
        while (busy !== 1'b0 && n < 5000) begin
            tick();
            n++;
        end
        chk({tag, "_idle_timeout"}, 64'(n < 5000), 64'd1);
        idle(3);
    endtask

    task automatic cmp_rx(input string tag);
        chk({tag, "_npkts"}, 64'(rxq.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < rxq.size(); i++)
            chk($sformatf("%s_pkt%0d", tag, i), rxq[i], expq[i]);
        chk({tag, "_idle_data"}, 64'(bad_idle), 64'd0);
        chk({tag, "_burst_len"}, 64'(bad_burst), 64'd0);
    endtask

    task automatic wait_en(input logic lvl, input string tag);
        int n = 0;
        @(negedge clk);
        while (en !== lvl && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_en_timeout"}, 64'(n < 500), 64'd1);
    endtask

    initial begin
        logic [63:0] p, pk[6];
        int spur, total, nr;

        sbif.sb_data_valid = 1'b0;
        sbif.sb_data = '0;
        clear_mon();
        tick();
        chk("rst_ser", 64'(ser), 64'd0);
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_crd", 64'(sbif.cfg_crd), 64'd0);
        chk("rst_cnt", 64'(pcnt), 64'd0);
        do_reset();

        // Single packet with latency from last word to first bit.
        p = 64'h0123456789ABCDEF;
        expq.push_back(p);
        send_pkt(p);
        @(negedge clk);
        chk("lat_en_e0", 64'(en), 64'd0);
        @(negedge clk);
        chk("lat_en_e1", 64'(en), 64'd1);
        chk("lat_bit0", 64'(ser), 64'(p[0]));
        chk("lat_crd", 64'(sbif.cfg_crd), 64'd1);
        tick();
        wait_idle("single");
        cmp_rx("single");
        chk("single_en_cyc", 64'(en_cyc), 64'd64);
        chk("single_crd", 64'(crd_cnt), 64'd1);
        chk("single_cnt", 64'(pcnt), 64'(exp_cnt(1)));

        // Three packets back to back.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pk[i] = rnd64();
            expq.push_back(pk[i]);
            send_pkt(pk[i]);
        end
        wait_idle("b2b");
        cmp_rx("b2b");
        chk("b2b_ngaps", 64'(gaps.size()), 64'd2);
        foreach (gaps[i]) chk($sformatf("b2b_gap%0d", i), 64'(gaps[i]), 64'(GAP));
        chk("b2b_crd", 64'(crd_cnt), 64'd3);
        chk("b2b_span", 64'(last_hi - first_hi + 1), 64'(3*PW + 2*GAP));
        chk("b2b_ovf", 64'(ovf), 64'd0);

        // Overflow: one in flight, FIFO fills, the rest are dropped.
        do_reset();
        for (int i = 0; i < DEPTH + 2; i++) begin
            pk[i] = rnd64();
            send_pkt(pk[i]);
        end
        chk("ovf_flag", 64'(ovf), 64'd1);
        for (int i = 0; i < DEPTH + 1; i++) expq.push_back(pk[i]);
        wait_idle("ovf");
        cmp_rx("ovf");
        chk("ovf_crd", 64'(crd_cnt), 64'(DEPTH + 1));
        chk("ovf_cnt", 64'(pcnt), 64'(exp_cnt(DEPTH + 1)));
        chk("ovf_sticky", 64'(ovf), 64'd1);

        // Full FIFO: last word lands on the edge that pops the next packet.
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            pk[i] = rnd64();
            expq.push_back(pk[i]);
            send_pkt(pk[i]);
        end
        wait_en(1'b1, "sim_hi");
        wait_en(1'b0, "sim_lo");
        repeat (GAP - 2) @(posedge clk);
        #1;
        pk[5] = rnd64();
        expq.push_back(pk[5]);
        send_pkt(pk[5]);
        chk("sim_no_ovf", 64'(ovf), 64'd0);
        wait_idle("sim");
        cmp_rx("sim");
        chk("sim_gap0", 64'(gaps.size() > 0 ? gaps[0] : -1), 64'(GAP));
        chk("sim_ovf_end", 64'(ovf), 64'd0);

        // Reset while bit 20 is on the lane.
        do_reset();
        p = rnd64();
        send_pkt(p);
        wait_en(1'b1, "rst_mid");
        repeat (20) @(negedge clk);
        chk("rst_mid_bit20", 64'(ser), 64'(p[20]));
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", 64'({ser, en, busy, ovf, sbif.cfg_crd, pcnt}), 64'd0);
        clear_mon();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mid_en_next", 64'(en), 64'd0);
        tick();
        rst_n = 1'b1;
        idle(120);
        chk("rst_mid_residual", 64'(en_cyc), 64'd0);
        p = rnd64();
        expq.push_back(p);
        send_pkt(p);
        wait_idle("rst_after");
        cmp_rx("rst_after");

        // Partial packet held across idle cycles.
        do_reset();
        p = rnd64();
        expq.push_back(p);
        send_word(p[31:0]);
        spur = 0;
        repeat (10) begin
            tick();
            if (en !== 1'b0 || busy !== 1'b0) spur++;
        end
        chk("hold_spurious", 64'(spur), 64'd0);
        send_word(p[63:32]);
        wait_idle("hold");
        cmp_rx("hold");

        // Random payloads with random spacing, never beyond capacity.
        do_reset();
        total = 0;
        for (int r = 0; r < 3; r++) begin
            nr = $urandom_range(1, DEPTH);
            for (int i = 0; i < nr; i++) begin
                p = rnd64();
                expq.push_back(p);
                send_word(p[31:0]);
                idle($urandom_range(0, 3));
                send_word(p[63:32]);
                idle($urandom_range(0, 3));
                total++;
            end
            wait_idle("rnd");
        end
        cmp_rx("rnd");
        chk("rnd_crd", 64'(crd_cnt), 64'(total));
        chk("rnd_cnt", 64'(pcnt), 64'(exp_cnt(total)));
        chk("rnd_ovf", 64'(ovf), 64'd0);
        foreach (gaps[i]) begin
            chk($sformatf("rnd_gap_min%0d", i), 64'(gaps[i] >= GAP), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
